// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the gated NAND SR latch driver.
// Op-code and FSM state enums plus the pulse/hold counter width.
package sr_latch_driver_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_SET    = 2'b01,
        OP_RESET  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/sr_latch_driver_cnt.sv
// Loadable down-counter with zero flag that times the PULSE and HOLD phases.
// Saturates at zero so a finished phase never wraps into the next one.
module sr_latch_driver_cnt
    import sr_latch_driver_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences s/r/en pulses into a gated NAND SR latch and reports completion.
// Optional feedback verification (CHECK state, err) is enabled by SR_LATCH_DRIVER_VERIFY_EN.
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       s,
    output logic       r,
    output logic       en,
    input  logic       q,
    input  logic       qn,
    output logic       done,
    output logic       err,
    output state_e     dbg_state
);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

`ifdef SR_LATCH_DRIVER_VERIFY_EN
    localparam state_e AFTER_HOLD = ST_CHECK;
`else
    localparam state_e AFTER_HOLD = ST_DONE;
`endif

    // Handshake: a request transfers on a rising edge with req_valid=1 and
    // req_ready=1; req_ready is high only in IDLE, anything else is dropped.
    state_e           state;
    state_e           state_nx;
    logic             set_op;
    logic             set_op_nx;
    logic             accept;
    logic             drive_nx;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    always_comb begin
        state_nx  = state;
        set_op_nx = set_op;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op_e'(req_op))
                        OP_NOP:   state_nx = ST_DONE;
                        OP_SET:   begin set_op_nx = 1'b1; state_nx = ST_SETUP; end
                        OP_RESET: begin set_op_nx = 1'b0; state_nx = ST_SETUP; end
                        default:  begin set_op_nx = !q;   state_nx = ST_SETUP; end
                    endcase
                end
            end
            ST_SETUP: state_nx = ST_PULSE;
            ST_PULSE: if (cnt_zero) state_nx = (HOLD_CYC == 0) ? AFTER_HOLD : ST_HOLD;
            ST_HOLD:  if (cnt_zero) state_nx = AFTER_HOLD;
            ST_CHECK: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Counter reloads on every state change; only PULSE and HOLD use its value.
    always_comb begin
        cnt_load = (state_nx != state);
        cnt_val  = '0;
        if (state_nx == ST_PULSE) cnt_val = PULSE_LD;
        else if (state_nx == ST_HOLD) cnt_val = HOLD_LD;
    end

    sr_latch_driver_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    assign drive_nx = (state_nx == ST_SETUP) || (state_nx == ST_PULSE) || (state_nx == ST_HOLD);

    // Outputs are registered from the next state so the latch sees glitch-free drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            set_op <= 1'b0;
            s      <= 1'b0;
            r      <= 1'b0;
            en     <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            set_op <= set_op_nx;
            s      <= drive_nx && set_op_nx;
            r      <= drive_nx && !set_op_nx;
            en     <= (state_nx == ST_PULSE);
            done   <= (state_nx == ST_DONE);
        end
    end

`ifdef SR_LATCH_DRIVER_VERIFY_EN
    logic chk_bad;
    assign chk_bad = set_op ? !(q && !qn) : !(!q && qn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= (state == ST_CHECK) && chk_bad;
        end
    end
`else
    logic unused_qn;
    assign unused_qn = qn;
    assign err       = 1'b0;
`endif

endmodule
